im_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the word-addressed instruction ROM. It owns the program counter and drives the ROM word address. It registers each returned instruction into a single-entry fetch register with a valid/ready handshake to decode. It also handles redirects (branch/jump/jr), halt detection and address-range/alignment errors.

---
 rtl/im_fetch_ctrl.sv | 174 +++++++++++++++++
 tb/tb_im_fetch_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the ROM and feeds a single-entry fetch register to decode.
// Optional `FETCH_PERF_EN adds saturating perf_fetch/perf_stall counters.
module im_fetch_ctrl #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] HALT_WORD = 32'h0000_000C
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [31:0]       im_instr,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [31:0]       if_pc,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              halted,
    output logic              fetch_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch,
    output logic [31:0]       perf_stall
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_HALT,
        S_ERROR
    } state_t;

    localparam logic [32:0] ROM_BYTES = 33'(1) << (ADDR_W + 2);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] if_instr_q;
    logic [31:0] if_pc_q;
    logic        if_valid_q;
    logic        halted_q;
    logic        fetch_err_q;

    logic [31:0] pc_off_d;
    logic [31:0] pc_next_d;
    logic        load_slot_d;
    logic        pc_bad_d;
    logic        redir_bad_d;
    logic        is_halt_d;
    logic        take_d;

    // Borrow out of the 33-bit subtraction flags pc below PC_RESET.
    function automatic logic pc_bad(input logic [31:0] pc);
        logic [32:0] off;
        off = {1'b0, pc} - {1'b0, PC_RESET};
        return (pc[1:0] != 2'b00) || off[32] || (off >= ROM_BYTES);
    endfunction

    always_comb begin
        pc_off_d    = pc_q - PC_RESET;
        pc_next_d   = pc_q + 32'd4;
        load_slot_d = !if_valid_q || if_ready;
        pc_bad_d    = pc_bad(pc_q);
        redir_bad_d = pc_bad(redirect_pc);
        is_halt_d   = (im_instr == HALT_WORD);
        take_d      = if_valid_q && if_ready;
    end

    assign im_addr   = ADDR_W'(pc_off_d >> 2);
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign halted    = halted_q;
    assign fetch_err = fetch_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= PC_RESET;
            if_instr_q  <= 32'd0;
            if_pc_q     <= 32'd0;
            if_valid_q  <= 1'b0;
            halted_q    <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                    end
                    if (start) begin
                        state_q <= S_RUN;
                    end
                end

                S_RUN, S_DRAIN: begin
                    if (redirect_valid) begin
                        // Redirect beats load, hold and halt; a squashed HALT_WORD resumes fetch.
                        pc_q       <= redirect_pc;
                        if_valid_q <= 1'b0;
                        if (redir_bad_d) begin
                            state_q     <= S_ERROR;
                            fetch_err_q <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end else if (state_q == S_DRAIN) begin
                        if (take_d) begin
                            if_valid_q <= 1'b0;
                            halted_q   <= 1'b1;
                            state_q    <= S_HALT;
                        end
                    end else if (pc_bad_d) begin
                        // Covers pc+4 running off the ROM and an unchecked IDLE redirect.
                        if_valid_q  <= 1'b0;
                        fetch_err_q <= 1'b1;
                        state_q     <= S_ERROR;
                    end else if (load_slot_d) begin
                        if_instr_q <= im_instr;
                        if_pc_q    <= pc_q;
                        if_valid_q <= 1'b1;
                        if (is_halt_d) begin
                            state_q <= S_DRAIN;
                        end else begin
                            pc_q <= pc_next_d;
                        end
                    end
                end

                S_HALT: begin
                    if_valid_q <= 1'b0;
                    halted_q   <= 1'b1;
                end

                S_ERROR: begin
                    if_valid_q  <= 1'b0;
                    fetch_err_q <= 1'b1;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;
    logic        perf_live_d;

    assign perf_live_d = (state_q == S_RUN) || (state_q == S_DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= 32'd0;
            perf_stall_q <= 32'd0;
        end else if (perf_live_d) begin
            if (take_d && (perf_fetch_q != 32'hFFFF_FFFF)) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (if_valid_q && !if_ready && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Self-checking bench for im_fetch_ctrl: ROM model, delivery scoreboard, error-vector table and hand sequences.
module tb_im_fetch_ctrl;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam int          ADDR_W    = 10;
    localparam logic [31:0] HALT_WORD = 32'h0000_000C;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_instr;
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_instr;
    logic [31:0]       if_pc;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              halted;
    logic              fetch_err;
`ifdef FETCH_PERF_EN
    logic [31:0]       perf_fetch;
    logic [31:0]       perf_stall;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] rpc;
        logic        exp_err;
    } evec_t;

    logic [31:0] rom [0:1023];
    exp_t        sb [$];
    evec_t       evec [8];
    int          total;
    int          bad;

    im_fetch_ctrl #(
        .PC_RESET (PC_RESET),
        .ADDR_W   (ADDR_W),
        .HALT_WORD(HALT_WORD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .im_addr       (im_addr),
        .im_instr      (im_instr),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halted        (halted),
        .fetch_err     (fetch_err)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch    (perf_fetch),
        .perf_stall    (perf_stall)
`endif
    );

    assign im_instr = rom[im_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want test done");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int w);
        sb.push_back(exp_t'{pc: PC_RESET + 32'(w) * 32'd4, instr: rom[w]});
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        if_ready       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic wait_halt(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && !halted; i++) step();
        check(name, 32'(halted), 32'd1);
    endtask

    // Every decode acceptance must match the oldest expected delivery.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && if_valid && if_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got pc %h want no delivery", if_pc);
            end else begin
                e = sb.pop_front();
                check("sb_pc", if_pc, e.pc);
                check("sb_instr", if_instr, e.instr);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 1024; i++) rom[i] = 32'hA000_0000 + 32'(i);
        rom[0] = 32'h0000_0011;
        rom[1] = 32'h0000_0022;
        rom[2] = 32'h0000_0033;
        rom[3] = HALT_WORD;

        evec[0] = '{32'h0000_3042, 1'b1};
        evec[1] = '{32'h0000_2FFC, 1'b1};
        evec[2] = '{32'h0000_3001, 1'b1};
        evec[3] = '{32'h0000_4000, 1'b1};
        evec[4] = '{32'h0000_0000, 1'b1};
        evec[5] = '{32'h0000_3010, 1'b0};
        evec[6] = '{32'h0000_3FF8, 1'b0};
        evec[7] = '{32'h0000_3000, 1'b0};

        // Reset state and straight-line fetch to HALT
        do_reset();
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_err", 32'(fetch_err), 32'd0);
        check("rst_addr", 32'(im_addr), 32'd0);
        if_ready = 1'b1;
        for (int w = 0; w < 4; w++) push(w);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t1_idle_load", 32'(if_valid), 32'd0);
        step();
        check("t1_first_pc", if_pc, 32'h0000_3000);
        step();
        check("t1_second_pc", if_pc, 32'h0000_3004);
        step();
        step();
        check("t1_halt_loaded", if_instr, HALT_WORD);
        check("t1_not_halted", 32'(halted), 32'd0);
        step();
        check("t1_halted", 32'(halted), 32'd1);
        check("t1_valid_off", 32'(if_valid), 32'd0);
        check("t1_addr_stop", 32'(im_addr), 32'd3);
        start          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3040;
        step();
        start          = 1'b0;
        redirect_valid = 1'b0;
        step();
        check("t1_halt_sticky", 32'(halted), 32'd1);
        check("t1_halt_addr", 32'(im_addr), 32'd3);
        check("t1_halt_novalid", 32'(if_valid), 32'd0);
        check("t1_sb_empty", 32'(sb.size()), 32'd0);
`ifdef FETCH_PERF_EN
        check("t1_perf_fetch", perf_fetch, 32'd4);
        check("t1_perf_stall", perf_stall, 32'd0);
`endif

        // Decode backpressure holds the fetch register
        do_reset();
        if_ready = 1'b1;
        for (int w = 0; w < 4; w++) push(w);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        if_ready = 1'b0;
        check("t2_hold_pc0", if_pc, 32'h0000_3004);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_hold_pc", if_pc, 32'h0000_3004);
            check("t2_hold_instr", if_instr, 32'h0000_0022);
            check("t2_hold_addr", 32'(im_addr), 32'd2);
        end
        if_ready = 1'b1;
        step();
        check("t2_resume_pc", if_pc, 32'h0000_3008);
        wait_halt("t2_halt", 10);
        check("t2_sb_empty", 32'(sb.size()), 32'd0);

        // Redirect flushes a held entry; new target two cycles later
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t3_held_valid", 32'(if_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3040;
        step();
        redirect_valid = 1'b0;
        check("t3_flush", 32'(if_valid), 32'd0);
        check("t3_addr", 32'(im_addr), 32'd16);
        if_ready = 1'b1;
        push(16);
        step();
        check("t3_new_pc", if_pc, 32'h0000_3040);
        check("t3_new_instr", if_instr, rom[16]);
        step();
        if_ready = 1'b0;
        check("t3_next_pc", if_pc, 32'h0000_3044);
        check("t3_sb_empty", 32'(sb.size()), 32'd0);

        // Redirect-target error table
        foreach (evec[i]) begin
            do_reset();
            start = 1'b1;
            step();
            start = 1'b0;
            step();
            redirect_valid = 1'b1;
            redirect_pc    = evec[i].rpc;
            step();
            redirect_valid = 1'b0;
            check("tv_err_now", 32'(fetch_err), 32'(evec[i].exp_err));
            check("tv_flush", 32'(if_valid), 32'd0);
            step();
            check("tv_err_later", 32'(fetch_err), 32'(evec[i].exp_err));
            check("tv_valid_later", 32'(if_valid), 32'(!evec[i].exp_err));
            if (!evec[i].exp_err) check("tv_target_pc", if_pc, evec[i].rpc);
        end

        // Error is sticky until reset
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3042;
        step();
        redirect_pc = 32'h0000_3010;
        if_ready    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start = 1'(i & 1);
            step();
            check("t4_err_sticky", 32'(fetch_err), 32'd1);
            check("t4_err_novalid", 32'(if_valid), 32'd0);
        end
        start          = 1'b0;
        redirect_valid = 1'b0;
        rst_n          = 1'b0;
        #1;
        check("t4_err_cleared", 32'(fetch_err), 32'd0);

        // Running off the last ROM word
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3FF8;
        step();
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        push(1022);
        push(1023);
        step();
        step();
        check("t7_last_pc", if_pc, 32'h0000_3FFC);
        check("t7_no_err_yet", 32'(fetch_err), 32'd0);
        step();
        check("t7_err", 32'(fetch_err), 32'd1);
        check("t7_flushed", 32'(if_valid), 32'd0);
        check("t7_sb_empty", 32'(sb.size()), 32'd0);

        // Redirect squashes a held HALT_WORD
        do_reset();
        if_ready = 1'b1;
        for (int w = 0; w < 3; w++) push(w);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        check("t5_halt_held", if_instr, HALT_WORD);
        if_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3010;
        step();
        redirect_valid = 1'b0;
        check("t5_flush", 32'(if_valid), 32'd0);
        check("t5_no_halt", 32'(halted), 32'd0);
        if_ready = 1'b1;
        push(4);
        step();
        check("t5_resume_pc", if_pc, 32'h0000_3010);
        check("t5_resume_instr", if_instr, rom[4]);
        step();
        if_ready = 1'b0;
        check("t5_next_pc", if_pc, 32'h0000_3014);
        check("t5_still_run", 32'(halted), 32'd0);
        check("t5_sb_empty", 32'(sb.size()), 32'd0);

        // Async reset mid-RUN, then IDLE-only redirect and restart
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_301C;
        step();
        redirect_valid = 1'b0;
        step();
        check("t6_pre_addr", 32'(im_addr), 32'd8);
        check("t6_pre_valid", 32'(if_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(if_valid), 32'd0);
        check("t6_rst_pc", if_pc, 32'd0);
        check("t6_rst_instr", if_instr, 32'd0);
        check("t6_rst_addr", 32'(im_addr), 32'd0);
        check("t6_rst_halted", 32'(halted), 32'd0);
        check("t6_rst_err", 32'(fetch_err), 32'd0);
        step();
        rst_n    = 1'b1;
        if_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_no_fetch", 32'(if_valid), 32'd0);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3040;
        step();
        redirect_valid = 1'b0;
        check("t6_idle_valid", 32'(if_valid), 32'd0);
        check("t6_idle_addr", 32'(im_addr), 32'd16);
        push(16);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t6_restart_pc", if_pc, 32'h0000_3040);
        step();
        if_ready = 1'b0;
        check("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
